// File: rtl/matrix_main_memory_pkg.sv
// Shared types and constants for the matrix ALU system memory map.
// Module-select codes, matrix element types and default memory contents.
package mem_pkg;

    typedef enum logic [3:0] {
        MOD_MAIN_MEM   = 4'h0,
        MOD_MATRIX_ALU = 4'h1,
        MOD_INT_ALU    = 4'h2
    } mod_sel_e;

    typedef logic [15:0]            elem_t;
    typedef logic [3:0][3:0][15:0] matrix_t;

    localparam matrix_t INIT0_DEF =
        256'h0001_0002_0003_0004_0005_0006_0007_0008_0009_000a_000b_000c_000d_000e_000f_0010;
    localparam matrix_t INIT1_DEF =
        256'h0020_001f_001e_001d_001c_001b_001a_0019_0018_0017_0016_0015_0014_0013_0012_0011;

    function automatic logic loc_in_range(input logic [11:0] loc, input int depth);
        return {20'd0, loc} < 32'(depth);
    endfunction

endpackage

// File: rtl/matrix_main_memory_if.sv
// Request/response bundle between a bus master and the matrix main memory.
// Signal names follow the legacy shared-bus naming.
interface matrix_main_memory_if #(
    parameter int DATA_W = 256,
    parameter int ELEM_W = 16
);
    localparam int ELEMS = DATA_W / ELEM_W;

    logic [15:0]       address;
    logic [DATA_W-1:0] DataIn;
    logic              nRead;
    logic              nWrite;
    logic [ELEMS-1:0]  elemEnable;
    logic [DATA_W-1:0] DataOut;
    logic              dataValid;
    logic              addrError;

    modport master (
        output address, DataIn, nRead, nWrite, elemEnable,
        input  DataOut, dataValid, addrError
    );

    modport slave (
        input  address, DataIn, nRead, nWrite, elemEnable,
        output DataOut, dataValid, addrError
    );

endinterface

// File: rtl/matrix_main_memory_read_delay_pipe.sv
// Depth-N shift register of {valid, data} used to stretch read latency.
// Invalid slots carry zero data so idle cycles do not toggle the data path.
module read_delay_pipe #(
    parameter int N = 2,
    parameter int W = 256
) (
    input  logic         Clk,
    input  logic         nReset,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    output logic [W-1:0] out_data
);

    logic [N-1:0]        v_q, v_d;
    logic [N-1:0][W-1:0] d_q, d_d;

    always_comb begin
        v_d    = v_q;
        d_d    = d_q;
        v_d[0] = in_valid;
        d_d[0] = in_valid ? in_data : '0;
        for (int i = 1; i < N; i++) begin
            v_d[i] = v_q[i-1];
            d_d[i] = d_q[i-1];
        end
    end

    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            v_q <= '0;
            d_q <= '0;
        end else begin
            v_q <= v_d;
            d_q <= d_d;
        end
    end

    assign out_valid = v_q[N-1];
    assign out_data  = d_q[N-1];

endmodule

// File: rtl/matrix_main_memory.sv
// Matrix main memory: masked element writes, pipelined reads with valid
// strobe, and range-error reporting for locations beyond DEPTH.
module matrix_main_memory
    import mem_pkg::*;
#(
    parameter int              DATA_W    = 256,
    parameter int              ELEM_W    = 16,
    parameter int              DEPTH     = 16,
    parameter logic [3:0]      MODULE_ID = MOD_MAIN_MEM,
    parameter int              READ_LAT  = 2,
    parameter logic [DATA_W-1:0] INIT0   = DATA_W'(INIT0_DEF),
    parameter logic [DATA_W-1:0] INIT1   = DATA_W'(INIT1_DEF)
) (
    input  logic Clk,
    input  logic nReset,
    matrix_main_memory_if.slave bus
);

    localparam int ELEMS = DATA_W / ELEM_W;
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];

    logic [11:0]       loc;
    logic [AW-1:0]     widx;
    logic              sel, in_rng, rd_req, wr_req;
    logic [DATA_W-1:0] rd_data;
    logic              pipe_valid;
    logic [DATA_W-1:0] pipe_data;

    logic              err_q, err_d;
    logic              addr_err_q, addr_err_d;
    logic              valid_q, valid_d;
    logic [DATA_W-1:0] data_out_q, data_out_d;

    always_comb begin
        loc     = bus.address[11:0];
        widx    = loc[AW-1:0];
        sel     = (bus.address[15:12] == MODULE_ID);
        in_rng  = loc_in_range(loc, DEPTH);
        rd_req  = sel & ~bus.nRead;
        wr_req  = sel & ~bus.nWrite & in_rng;
        rd_data = in_rng ? mem_q[widx] : '0;
        // error is staged once so it lands one edge after the request edge
        err_d      = sel & (~bus.nRead | ~bus.nWrite) & ~in_rng;
        addr_err_d = err_q;
        valid_d    = pipe_valid;
        data_out_d = pipe_valid ? pipe_data : data_out_q;
    end

    always_comb begin
        mem_d = mem_q;
        if (wr_req) begin
            for (int i = 0; i < ELEMS; i++) begin
                if (bus.elemEnable[i]) begin
                    mem_d[widx][i*ELEM_W +: ELEM_W] = bus.DataIn[i*ELEM_W +: ELEM_W];
                end
            end
        end
    end

    read_delay_pipe #(
        .N (READ_LAT),
        .W (DATA_W)
    ) u_pipe (
        .Clk       (Clk),
        .nReset    (nReset),
        .in_valid  (rd_req),
        .in_data   (rd_data),
        .out_valid (pipe_valid),
        .out_data  (pipe_data)
    );

    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            for (int k = 0; k < DEPTH; k++) begin
                mem_q[k] <= (k == 0) ? INIT0 : (k == 1) ? INIT1 : '0;
            end
            err_q      <= 1'b0;
            addr_err_q <= 1'b0;
            valid_q    <= 1'b0;
            data_out_q <= '0;
        end else begin
            mem_q      <= mem_d;
            err_q      <= err_d;
            addr_err_q <= addr_err_d;
            valid_q    <= valid_d;
            data_out_q <= data_out_d;
        end
    end

    assign bus.DataOut   = data_out_q;
    assign bus.dataValid = valid_q;
    assign bus.addrError = addr_err_q;

endmodule

// File: doc/matrix_main_memory.md
Name: matrix_main_memory

Overview:
Parametrised main memory for the matrix ALU system. Each word holds one 4x4 matrix of 16-bit elements (256 bits at defaults). The block decodes its own module-select field from the shared 16-bit address bus. Over the current single-cycle main memory it adds:
- configurable depth and data width
- per-element write masking
- a configurable read-latency pipeline with a valid strobe
- out-of-range address error reporting

Parameters:
DATA_W, 256, word width in bits; must be a multiple of ELEM_W
ELEM_W, 16, matrix element width; ELEMS = DATA_W/ELEM_W
DEPTH, 16, number of words; legal range 2..4096
MODULE_ID, 4'h0, value of address[15:12] that selects this block
READ_LAT, 2, cycles from read request edge to DataOut/dataValid update; legal range 1..4
INIT0, 256'h0001_0002_…_0010, reset contents of word 0
INIT1, 256'h0020_001f_…_0011, reset contents of word 1

Ports:
Clk  in  1  clock, all state updates on rising edge
nReset  in  1  asynchronous active-low reset
address  in  16  [15:12] module select, [11:0] word location
DataIn  in  DATA_W  write data
nRead  in  1  active-low read request, sampled on each Clk edge
nWrite  in  1  active-low write request, sampled on each Clk edge
elemEnable  in  ELEMS  active-high per-element write mask; bit i covers DataIn[i*ELEM_W +: ELEM_W]
DataOut  out  DATA_W  registered read data; holds its value between reads
dataValid  out  1  one-cycle pulse when DataOut carries new read data
addrError  out  1  one-cycle pulse, one cycle after a selected request whose location is >= DEPTH

Behaviour:
- Reset (async assert, nReset low):
  - mem[0]=INIT0, mem[1]=INIT1, all other words 0
  - DataOut=0, dataValid=0, addrError=0
  - read pipeline flushed
- Select: the block is selected when address[15:12]==MODULE_ID. Unselected requests are ignored with no side effects.
- Write: on an edge where the block is selected, nWrite=0 and location<DEPTH:
  - each element i with elemEnable[i]=1 is updated
  - each element with elemEnable[i]=0 keeps its old value
  - elemEnable all-zero is a no-op write
- Read: on an edge where the block is selected and nRead=0:
  - a request enters a READ_LAT-deep pipeline (valid bit + data)
  - the array is sampled at the request edge N
  - at edge N+READ_LAT: DataOut is loaded and dataValid=1 for one cycle
  - one read may be issued per cycle, so back-to-back reads produce back-to-back valids
- Read and write together (nRead=0 and nWrite=0 in the same cycle): both are performed.
  - Same location: the read returns the pre-write data (read-before-write).
  - The written data is visible to reads issued on the following cycle or later.
- Out of range (location >= DEPTH, block selected):
  - no array write
  - a read still occupies the pipeline and returns DataOut=0 with dataValid=1 at N+READ_LAT
  - addrError=1 at edge N+1
- READ_LAT=1 reproduces the legacy timing: data is visible one edge after the request.
- Reset mid-operation: in-flight reads are discarded, and no dataValid is produced for requests issued before reset.
- Reset deassertion: the first edge after nReset rises accepts requests normally.
- Location width: address[11:0] is used unmodified. There is no wrap-around; locations >= DEPTH are errors, not aliases.

Decomposition:
- Shared package mem_pkg:
  - module-select constants (MOD_MAIN_MEM=4'h0, MOD_MATRIX_ALU, MOD_INT_ALU, …)
  - typedefs elem_t (logic [15:0]) and matrix_t (logic [3:0][3:0][15:0])
  - default INIT constants
- One sub-module, read_delay_pipe: a parametrised depth-N shift register of {valid, data} with async active-low reset.

Test Plan:
1. Reset with defaults, then read loc 0 at edge N and loc 1 at edge N+1 → DataOut=INIT0 with dataValid=1 at N+2, INIT1 at N+3; dataValid low at all other edges.
2. Write DataIn all 16'hffff, elemEnable=16'h0001, loc 0; then read loc 0 → 0001_0002_…_000f_ffff (only element 0 changed).
3. Same-cycle read+write to loc 3 (prior value 0) with DataIn=all 16'h1234, elemEnable=16'hffff → first read returns 0; a read the next cycle returns all 16'h1234.
4. With DEPTH=16, write then read loc 16'h0014 → addrError pulses one cycle after each request; the read returns 0 with dataValid; mem[4] is unchanged.
5. address[15:12]=4'h1 with nRead=0 and nWrite=0 → no dataValid, no addrError, memory unchanged.
6. Issue a read, then assert nReset one cycle later → no dataValid ever appears; after release, mem[0] reads back INIT0, including when mem[0] was overwritten before the reset.
